// File: rtl/mat_mat_if.sv
// Streaming handshake bundle for mat_mat: serial operand input and
// parallel result-row output.
interface mat_mat_if #(
   parameter int unsigned elementsNum = 3,
   parameter int unsigned dataWidth   = 4
);
   localparam int unsigned OW = 2 * dataWidth + $clog2(elementsNum) + 1;

   logic [dataWidth-1:0] in;
   logic                 valid_in;
   logic                 ready_in;
   logic                 ready_out;
   logic [OW-1:0]        out [elementsNum];
   logic                 valid_out;

   modport slave (
      input  in, valid_in, ready_out,
      output ready_in, out, valid_out
   );

   modport master (
      output in, valid_in, ready_out,
      input  ready_in, out, valid_out
   );
endinterface

// File: rtl/mat_mat.sv
// Streaming unsigned NxN matrix-matrix multiplier. Loads A then B serially
// (row-major), computes C = A x B one row at a time in N cycles per row and
// presents each row on a parallel bus until the downstream handshake.
module mat_mat #(
   parameter int unsigned elementsNum = 3,
   parameter int unsigned dataWidth   = 4
) (
   input logic      clk,
   input logic      rst,
   mat_mat_if.slave bus
);
   localparam int unsigned N  = elementsNum;
   localparam int unsigned DW = dataWidth;
   localparam int unsigned OW = 2 * DW + $clog2(N) + 1;
   localparam int unsigned NN = N * N;
   localparam int unsigned AW = $clog2(NN);
   localparam int unsigned CW = $clog2(2 * NN);
   localparam int unsigned RW = $clog2(N);

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] r_q;
   logic [RW-1:0] k_q;
   logic [OW-1:0] acc_q [N];
   logic [OW-1:0] out_q [N];
   logic          valid_out_q;

   logic [DW-1:0] a_q [NN];
   logic [DW-1:0] b_q [NN];

   logic          accept;
   logic          last_elem;
   logic          wr_b;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] a_idx;
   logic [AW-1:0] b_idx [N];
   logic [OW-1:0] sum_d [N];

   // Input acceptance, storage addressing and the per-column multiply-accumulate.
   always_comb begin
      accept    = (state_q == LOAD) && bus.valid_in;
      last_elem = (cnt_q == CW'(2 * NN - 1));
      wr_b      = (cnt_q >= CW'(NN));
      wr_idx    = wr_b ? AW'(cnt_q - CW'(NN)) : AW'(cnt_q);
      a_idx     = AW'(32'(r_q) * N + 32'(k_q));
      for (int unsigned j = 0; j < N; j++) begin
         b_idx[j] = AW'(32'(k_q) * N + j);
         sum_d[j] = acc_q[j] + OW'(a_q[a_idx]) * OW'(b_q[b_idx[j]]);
      end
   end

   // Operand storage; deliberately not reset, each matrix pair overwrites it fully.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (wr_b) b_q[wr_idx] <= bus.in;
         else      a_q[wr_idx] <= bus.in;
      end
   end

   // Control FSM with registered result row and valid flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         r_q         <= '0;
         k_q         <= '0;
         valid_out_q <= 1'b0;
         for (int unsigned j = 0; j < N; j++) begin
            acc_q[j] <= '0;
            out_q[j] <= '0;
         end
      end else begin
         case (state_q)
            LOAD: begin
               if (accept) begin
                  if (last_elem) begin
                     state_q <= COMPUTE;
                     r_q     <= '0;
                     k_q     <= '0;
                     for (int unsigned j = 0; j < N; j++) acc_q[j] <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               for (int unsigned j = 0; j < N; j++) acc_q[j] <= sum_d[j];
               if (k_q == RW'(N - 1)) begin
                  // Final term is folded in directly so the row is ready on this edge.
                  for (int unsigned j = 0; j < N; j++) out_q[j] <= sum_d[j];
                  valid_out_q <= 1'b1;
                  k_q         <= '0;
                  state_q     <= OUTPUT;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            OUTPUT: begin
               if (bus.ready_out) begin
                  valid_out_q <= 1'b0;
                  for (int unsigned j = 0; j < N; j++) acc_q[j] <= '0;
                  if (r_q == RW'(N - 1)) begin
                     state_q <= LOAD;
                     cnt_q   <= '0;
                     r_q     <= '0;
                  end else begin
                     r_q     <= r_q + 1'b1;
                     state_q <= COMPUTE;
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign bus.ready_in  = (state_q == LOAD);
   assign bus.valid_out = valid_out_q;
   assign bus.out       = out_q;

endmodule

// File: tb/tb_mat_mat.sv
// Scoreboard bench for mat_mat (N=3, DW=4): expected rows are queued as
// stimulus is issued; a negedge monitor compares every delivered row.
module tb_mat_mat;
   localparam int unsigned N  = 3;
   localparam int unsigned DW = 4;
   localparam int unsigned OW = 2 * DW + $clog2(N) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mat_mat_if #(.elementsNum(N), .dataWidth(DW)) bus ();

   mat_mat #(.elementsNum(N), .dataWidth(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [N*OW-1:0] exp_q [$];
   logic [N*OW-1:0] mon_exp;
   logic [N*OW-1:0] snap;
   int va [9];
   int vb [9];
   int lat;

   function automatic logic [N*OW-1:0] row3(input int c0, input int c1, input int c2);
      return {OW'(c2), OW'(c1), OW'(c0)};
   endfunction

   function automatic logic [N*OW-1:0] cur_row();
      logic [N*OW-1:0] r;
      for (int j = 0; j < N; j++) r[j*OW +: OW] = bus.out[j];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Row monitor: a row is consumed on the edge following a negedge with valid&ready.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL row_unexpected actual=%0h expected=none", cur_row());
         end else begin
            mon_exp = exp_q.pop_front();
            if (cur_row() !== mon_exp) begin
               errors++;
               $display("FAIL row actual=%0h expected=%0h", cur_row(), mon_exp);
            end
         end
      end
   end

   task automatic send(input int v);
      int n;
      bus.in       = DW'(v);
      bus.valid_in = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.ready_in) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 1, 0);
            bus.valid_in = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic load(input int a [9], input int b [9], input bit gaps);
      for (int i = 0; i < 9; i++) begin
         send(a[i]);
         if (gaps) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 9; i++) begin
         send(b[i]);
         if (gaps) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.valid_out && n < 200);
      if (!bus.valid_out) check("valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in        = '0;
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready_in", bus.ready_in, 1);
      check("reset_valid_out", bus.valid_out, 0);
      check("reset_out", cur_row(), 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // Identity x [1..9], with first-row latency
      bus.ready_out = 1'b1;
      va = '{1,0,0, 0,1,0, 0,0,1};
      vb = '{1,2,3, 4,5,6, 7,8,9};
      exp_q.push_back(row3(1,2,3));
      exp_q.push_back(row3(4,5,6));
      exp_q.push_back(row3(7,8,9));
      load(va, vb, 1'b0);
      check("ident_ready_in_low", bus.ready_in, 0);
      wait_valid(lat);
      check("ident_latency", lat, N);
      drain();
      check("ident_ready_in_back", bus.ready_in, 1);

      // Maximum operand values
      va = '{15,15,15, 15,15,15, 15,15,15};
      vb = '{15,15,15, 15,15,15, 15,15,15};
      repeat (3) exp_q.push_back(row3(675,675,675));
      load(va, vb, 1'b0);
      drain();

      // Input gaps plus output backpressure on row 0
      bus.ready_out = 1'b0;
      va = '{1,2,3, 4,5,6, 7,8,9};
      vb = '{9,8,7, 6,5,4, 3,2,1};
      exp_q.push_back(row3(30,24,18));
      exp_q.push_back(row3(84,69,54));
      exp_q.push_back(row3(138,114,90));
      load(va, vb, 1'b1);
      check("gap_ready_in_low", bus.ready_in, 0);
      wait_valid(lat);
      snap = cur_row();
      check("bp_row0_value", snap, row3(30,24,18));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("bp_valid_hold", bus.valid_out, 1);
         check("bp_out_hold", cur_row(), snap);
         check("bp_ready_in_low", bus.ready_in, 0);
      end
      bus.ready_out = 1'b1;
      @(posedge clk); #1;
      check("bp_handshake_clears_valid", bus.valid_out, 0);
      check("bp_out_kept", cur_row(), snap);
      wait_valid(lat);
      check("bp_row1_latency", lat, N);
      drain();
      check("gap_ready_in_back", bus.ready_in, 1);

      // Reset partway through loading
      for (int i = 1; i <= 5; i++) send(i + 6);
      rst = 1'b0;
      #2;
      check("midrst_ready_in", bus.ready_in, 1);
      check("midrst_valid_out", bus.valid_out, 0);
      check("midrst_out", cur_row(), 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_still_idle", bus.valid_out, 0);
      va = '{2,0,0, 0,2,0, 0,0,2};
      vb = '{1,2,3, 4,5,6, 7,8,9};
      exp_q.push_back(row3(2,4,6));
      exp_q.push_back(row3(8,10,12));
      exp_q.push_back(row3(14,16,18));
      load(va, vb, 1'b0);
      drain();

      // Back-to-back matrix pairs
      exp_q.push_back(row3(1,2,3));
      exp_q.push_back(row3(4,5,6));
      exp_q.push_back(row3(7,8,9));
      exp_q.push_back(row3(9,8,7));
      exp_q.push_back(row3(6,5,4));
      exp_q.push_back(row3(3,2,1));
      va = '{1,2,3, 4,5,6, 7,8,9};
      vb = '{1,0,0, 0,1,0, 0,0,1};
      load(va, vb, 1'b0);
      va = '{1,0,0, 0,1,0, 0,0,1};
      vb = '{9,8,7, 6,5,4, 3,2,1};
      load(va, vb, 1'b0);
      drain();
      check("b2b_ready_in_back", bus.ready_in, 1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
